eth_frame_gen: RTL and testbench

Synthesizable, parametrised Ethernet test-frame generator. It drives a GMII-style byte stream (`dv`/`er`/`data`) into a switch ingress port. Each frame carries a preamble, SFD, DA, SA, a counter-stamped payload and a correct IEEE 802.3 FCS, followed by a programmable inter-frame gap. Destination port rotates round-robin or stays fixed, frame length is runtime-selectable, and error injection is optional.

---
 rtl/eth_frame_gen.sv | 213 +++++++++++++++++++++
 tb/tb_eth_frame_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_gen.sv
// GMII-style Ethernet test-frame generator: preamble, DA/SA header, counter-stamped payload,
// on-the-fly CRC-32 FCS and a programmable inter-frame gap. All outputs are registered.
module eth_frame_gen #(
    parameter int NUM_PORTS = 4,
    parameter int SA_PORT   = 3,
    parameter int MAX_LEN   = 1518,
    parameter int IFG       = 12,
    parameter int LEN_W     = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [LEN_W-1:0] len,
    input  logic             dst_mode,
    input  logic [7:0]       dst_fixed,
    input  logic             err_inject,
    output logic             dv,
    output logic             er,
    output logic [7:0]       data,
    output logic             frame_done,
    output logic             busy,
    output logic [15:0]      frame_cnt
);

    localparam int CW = $clog2(((MAX_LEN > IFG) ? MAX_LEN : IFG) + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_PAY  = 3'd3;
    localparam logic [2:0] S_FCS  = 3'd4;
    localparam logic [2:0] S_GAP  = 3'd5;

    localparam logic [7:0]    SA_BYTE  = 8'(SA_PORT);
    localparam logic [7:0]    ROT_INIT = (SA_PORT == 0) ? 8'd1 : 8'd0;
    localparam logic [CW-1:0] GAP_LAST = CW'(IFG - 1);

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Next port in the rotation, skipping our own port.
    function automatic logic [7:0] rot_advance(input logic [7:0] r);
        logic [7:0] n;
        n = r + 8'd1;
        if (int'(n) >= NUM_PORTS) n = 8'd0;
        if (n == SA_BYTE) n = n + 8'd1;
        if (int'(n) >= NUM_PORTS) n = 8'd0;
        return n;
    endfunction

    logic [2:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [CW-1:0] len_reg;
    logic [7:0]    dst_reg;
    logic          mode_reg;
    logic          err_reg;
    logic [7:0]    rot_reg;
    logic [31:0]   crc_reg;
    logic          dv_reg, er_reg, frame_done_reg, busy_reg;
    logic [7:0]    data_reg;
    logic [15:0]   frame_cnt_reg;

    logic [CW-1:0] len_eff;
    logic [CW-1:0] pay_last;
    logic [31:0]   fcs_word;
    logic [7:0]    byte_val;
    logic          byte_dv, byte_er, crc_upd, done, start;

    always_comb begin
        if (int'(len) < 64)           len_eff = CW'(64);
        else if (int'(len) > MAX_LEN) len_eff = CW'(MAX_LEN);
        else                          len_eff = CW'(len);
    end

    // Payload spans len-16 bytes, so its last index is len-17.
    assign pay_last = len_reg - CW'(17);
    assign fcs_word = ~crc_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CW'(1);
        byte_val   = 8'h00;
        byte_dv    = 1'b0;
        byte_er    = 1'b0;
        crc_upd    = 1'b0;
        done       = 1'b0;
        start      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (en) begin
                    state_next = S_PRE;
                    start      = 1'b1;
                end
            end
            S_PRE: begin
                byte_dv  = 1'b1;
                byte_val = (cnt_reg == CW'(7)) ? 8'hD5 : 8'h55;
                if (cnt_reg == CW'(7)) begin
                    state_next = S_HDR;
                    cnt_next   = '0;
                end
            end
            S_HDR: begin
                byte_dv = 1'b1;
                crc_upd = 1'b1;
                case (int'(cnt_reg))
                    0, 1:    byte_val = dst_reg;
                    6, 7:    byte_val = SA_BYTE;
                    default: byte_val = 8'h00;
                endcase
                if (cnt_reg == CW'(11)) begin
                    state_next = S_PAY;
                    cnt_next   = '0;
                end
            end
            S_PAY: begin
                byte_dv = 1'b1;
                crc_upd = 1'b1;
                if (cnt_reg == pay_last) begin
                    byte_val   = frame_cnt_reg[7:0];
                    byte_er    = err_reg;
                    state_next = S_FCS;
                    cnt_next   = '0;
                end
            end
            S_FCS: begin
                byte_dv = 1'b1;
                case (cnt_reg[1:0])
                    2'd0:    byte_val = fcs_word[7:0];
                    2'd1:    byte_val = fcs_word[15:8];
                    2'd2:    byte_val = fcs_word[23:16];
                    default: byte_val = fcs_word[31:24];
                endcase
                if (cnt_reg == CW'(3)) begin
                    done       = 1'b1;
                    state_next = S_GAP;
                    cnt_next   = '0;
                end
            end
            S_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next = '0;
                    if (en) begin
                        state_next = S_PRE;
                        start      = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            len_reg        <= CW'(64);
            dst_reg        <= 8'h00;
            mode_reg       <= 1'b0;
            err_reg        <= 1'b0;
            rot_reg        <= ROT_INIT;
            crc_reg        <= 32'hFFFFFFFF;
            dv_reg         <= 1'b0;
            er_reg         <= 1'b0;
            data_reg       <= 8'h00;
            frame_done_reg <= 1'b0;
            busy_reg       <= 1'b0;
            frame_cnt_reg  <= 16'h0000;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            busy_reg       <= (state_next != S_IDLE);
            dv_reg         <= byte_dv;
            er_reg         <= byte_er;
            data_reg       <= byte_val;
            frame_done_reg <= done;
            // Per-frame parameters are frozen here so mid-frame input changes cannot leak in.
            if (start) begin
                len_reg  <= len_eff;
                err_reg  <= err_inject;
                mode_reg <= dst_mode;
                dst_reg  <= dst_mode ? dst_fixed : rot_reg;
                crc_reg  <= 32'hFFFFFFFF;
            end else if (crc_upd) begin
                crc_reg <= crc_step(crc_reg, byte_val);
            end
            if (done) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
                if (!mode_reg) rot_reg <= rot_advance(rot_reg);
            end
        end
    end

    assign dv         = dv_reg;
    assign er         = er_reg;
    assign data       = data_reg;
    assign frame_done = frame_done_reg;
    assign busy       = busy_reg;
    assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_eth_frame_gen.sv
// Bench for eth_frame_gen: a frame-level model predicts every output cycle; captured frames
// are also checked against hand-computed literals (lengths, DA rotation, CRC residue, er).
module tb_eth_frame_gen;
    localparam int NUM_PORTS = 4;
    localparam int SA_PORT   = 3;
    localparam int MAX_LEN   = 1518;
    localparam int IFG       = 12;
    localparam int LEN_W     = 11;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [LEN_W-1:0] len;
    logic             dst_mode;
    logic [7:0]       dst_fixed;
    logic             err_inject;
    logic             dv, er, frame_done, busy;
    logic [7:0]       data;
    logic [15:0]      frame_cnt;

    eth_frame_gen #(
        .NUM_PORTS(NUM_PORTS), .SA_PORT(SA_PORT), .MAX_LEN(MAX_LEN), .IFG(IFG), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .len(len), .dst_mode(dst_mode),
        .dst_fixed(dst_fixed), .err_inject(err_inject), .dv(dv), .er(er), .data(data),
        .frame_done(frame_done), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Bit-serial reflected CRC-32 (LSB of each byte first).
    function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // ---------------- behavioural model: one expected entry per output cycle ----------------
    typedef struct {
        logic        dv;
        logic        er;
        logic [7:0]  data;
        logic        done;
        logic        busy;
        logic [15:0] fcnt;
    } ent_t;

    ent_t        exp_q[$];
    ent_t        cur;
    bit          have = 0;
    logic [15:0] mcnt = 16'h0;
    int          ri   = 0;
    int          rot_seq[$];

    function automatic ent_t mk(input logic d, input logic e, input logic [7:0] b,
                                input logic dn, input logic bz, input logic [15:0] fc);
        ent_t x;
        x.dv = d; x.er = e; x.data = b; x.done = dn; x.busy = bz; x.fcnt = fc;
        return x;
    endfunction

    task automatic build(input int ln, input logic mode, input logic [7:0] dfix, input logic err);
        logic [7:0]  fr[$];
        logic [7:0]  dst;
        logic [31:0] crc;
        int          le;
        int          last;
        le  = (ln < 64) ? 64 : ((ln > MAX_LEN) ? MAX_LEN : ln);
        dst = mode ? dfix : 8'(rot_seq[ri]);
        for (int i = 0; i < 7; i++) fr.push_back(8'h55);
        fr.push_back(8'hD5);
        fr.push_back(dst); fr.push_back(dst);
        for (int i = 0; i < 4; i++) fr.push_back(8'h00);
        fr.push_back(8'(SA_PORT)); fr.push_back(8'(SA_PORT));
        for (int i = 0; i < 4; i++) fr.push_back(8'h00);
        for (int i = 0; i < le - 17; i++) fr.push_back(8'h00);
        fr.push_back(mcnt[7:0]);
        crc = 32'hFFFFFFFF;
        for (int i = 8; i < fr.size(); i++) crc = crc_bits(crc, fr[i]);
        crc = ~crc;
        for (int i = 0; i < 4; i++) fr.push_back(crc[8*i +: 8]);
        last = fr.size() - 1;
        exp_q.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, mcnt));
        for (int i = 0; i <= last; i++)
            exp_q.push_back(mk(1'b1, err && (i == last - 4), fr[i], i == last, 1'b1,
                               (i == last) ? mcnt + 16'd1 : mcnt));
        for (int i = 0; i < IFG - 1; i++)
            exp_q.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, mcnt + 16'd1));
        mcnt = mcnt + 16'd1;
        if (!mode) ri = (ri + 1) % rot_seq.size();
    endtask

    initial begin
        for (int p = 0; p < NUM_PORTS; p++) if (p != SA_PORT) rot_seq.push_back(p);
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                exp_q.delete(); mcnt = 16'h0; ri = 0; have = 0;
            end else begin
                if (exp_q.size() == 0) begin
                    if (en) build(int'(len), dst_mode, dst_fixed, err_inject);
                    else    exp_q.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, mcnt));
                end
                cur  = exp_q.pop_front();
                have = 1;
            end
        end
    end

    // Per-cycle compare; data is only meaningful while dv is high.
    initial forever begin
        @(negedge clk);
        if (rst_n && have)
            chk("cycle", {36'h0, dv, er, (dv ? data : 8'h00), frame_done, busy, frame_cnt},
                {36'h0, cur.dv, cur.er, cur.data, cur.done, cur.busy, cur.fcnt});
    end

    // ---------------- frame capture from the DUT stream ----------------
    typedef struct {
        int          len;
        logic [7:0]  b0, b7, da, sa, last_pay;
        int          er_cnt, er_pos;
        logic [31:0] res;
    } rec_t;

    rec_t       frames[$];
    logic [7:0] cb[$];
    int         cap_er_cnt = 0;
    int         cap_er_pos = -1;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            cb.delete(); cap_er_cnt = 0; cap_er_pos = -1;
        end else if (dv) begin
            if (er) begin cap_er_cnt++; cap_er_pos = cb.size(); end
            cb.push_back(data);
        end else if (cb.size() > 0) begin
            rec_t r;
            r.len = cb.size(); r.er_cnt = cap_er_cnt; r.er_pos = cap_er_pos;
            r.b0 = 8'h0; r.b7 = 8'h0; r.da = 8'h0; r.sa = 8'h0; r.last_pay = 8'h0; r.res = 32'h0;
            if (cb.size() >= 28) begin
                r.b0 = cb[0]; r.b7 = cb[7]; r.da = cb[8]; r.sa = cb[14];
                r.last_pay = cb[cb.size() - 5];
                r.res = 32'hFFFFFFFF;
                for (int i = 8; i < cb.size(); i++) r.res = crc_bits(r.res, cb[i]);
            end
            frames.push_back(r);
            cb.delete(); cap_er_cnt = 0; cap_er_pos = -1;
        end
    end

    task automatic wait_frames(input int n, input int budget);
        int c;
        c = 0;
        while (frames.size() < n && c < budget) begin @(negedge clk); c++; end
        chk("wait_frames", 64'(frames.size() >= n), 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (busy !== 1'b0 && c < budget) begin @(negedge clk); c++; end
        chk("wait_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int nb;
        rst_n = 1'b0; en = 1'b0; len = 11'd64; dst_mode = 1'b0; dst_fixed = 8'h00; err_inject = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {dv, er, data, frame_done, busy, frame_cnt}, 64'h0);
        rst_n = 1'b1; en = 1'b1;

        // Four round-robin frames of 64 bytes.
        wait_frames(4, 400);
        en = 1'b0;
        wait_idle(100);
        chk("f0_len",  frames[0].len, 72);
        chk("f0_pre",  {frames[0].b0, frames[0].b7}, 16'h55D5);
        chk("f0_sa",   frames[0].sa, 8'h03);
        chk("f0_res",  frames[0].res, 32'hDEBB20E3);
        chk("f0_er",   frames[0].er_cnt, 0);
        chk("rr_da",   {frames[0].da, frames[1].da, frames[2].da, frames[3].da}, 32'h00010200);
        chk("rr_pay",  {frames[0].last_pay, frames[1].last_pay, frames[2].last_pay,
                        frames[3].last_pay}, 32'h00010203);
        chk("cnt4",    frame_cnt, 16'd4);

        // Clamping; len changed mid-frame must not affect the running frame.
        nb = frames.size();
        len = 11'd10; en = 1'b1;
        @(negedge clk); @(negedge clk);
        len = 11'd2000;
        wait_frames(nb + 2, 3000);
        chk("clamp_low",  frames[nb].len, 72);
        chk("clamp_high", frames[nb + 1].len, 1526);
        chk("clamp_res",  frames[nb + 1].res, 32'hDEBB20E3);

        // Error injection, then en dropped during PAY.
        len = 11'd64; err_inject = 1'b1;
        repeat (40) @(negedge clk);
        en = 1'b0; err_inject = 1'b0;
        wait_frames(nb + 3, 200);
        wait_idle(100);
        chk("err_len", frames[nb + 2].len, 72);
        chk("err_cnt", frames[nb + 2].er_cnt, 1);
        chk("err_pos", frames[nb + 2].er_pos, 67);
        chk("err_res", frames[nb + 2].res, 32'hDEBB20E3);
        repeat (30) @(negedge clk);
        chk("no_more_frames", frames.size(), nb + 3);

        // Asynchronous reset mid-payload.
        len = 11'd200; en = 1'b1;
        repeat (60) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {dv, er, data, frame_done, busy, frame_cnt}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        nb = frames.size();
        wait_frames(nb + 1, 400);
        chk("post_rst_len", frames[nb].len, 208);
        chk("post_rst_hdr", {frames[nb].b0, frames[nb].da, frames[nb].last_pay}, 24'h550000);
        chk("post_rst_res", frames[nb].res, 32'hDEBB20E3);

        // Randomised traffic: inputs wander every cycle, only frame-start values matter.
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            en         = ($urandom_range(0, 99) < 95);
            case ($urandom_range(0, 3))
                0:       len = LEN_W'($urandom_range(0, 80));
                1, 2:    len = LEN_W'($urandom_range(60, 260));
                default: len = LEN_W'($urandom_range(0, 2047));
            endcase
            dst_mode   = 1'($urandom_range(0, 1));
            dst_fixed  = 8'($urandom_range(0, 255));
            err_inject = 1'($urandom_range(0, 1));
        end
        en = 1'b0;
        wait_idle(3000);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
